// File: rtl/mul_hilo_pkg.sv
// Shared constants for the HI/LO multiply front-end.
// State encodings, default sizes and HI/LO select codes.
package mul_hilo_pkg;

  localparam int W_DEF       = 16;
  localparam int MAX_CYC_DEF = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_CAPT  = 2'd3;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/mul_watchdog.sv
// Clearable up-counter; tc flags count == MAX_CYC-1.
// Ports: clk, rst (async high), en (count, else clear), tc.
module mul_watchdog
  import mul_hilo_pkg::*;
#(
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(MAX_CYC);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(MAX_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!en)
      cnt <= '0;
    else if (!tc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// HI/LO front-end for a shift-add multiplier: MULT launch, MFHI/MFLO reads.
// Ports: mult_req/op_a/op_b/mult_ack, mf_req/mf_sel/rd_data/rd_valid, stall,
// busy, err, mul_st/mul_mndo/mul_mdor/mul_prod/mul_done.
// Option MUL_HILO_MT_EN adds mt_req/mt_sel/mt_data direct HI/LO writes.
module mul_hilo_ctrl
  import mul_hilo_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mult_req,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         mult_ack,
  input  logic         mf_req,
  input  logic         mf_sel,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         stall,
  output logic         busy,
  output logic         err,
  output logic         mul_st,
  output logic [W-1:0] mul_mndo,
  output logic [W-1:0] mul_mdor,
  input  logic [2*W-1:0] mul_prod,
  input  logic         mul_done
`ifdef MUL_HILO_MT_EN
  ,
  input  logic         mt_req,
  input  logic         mt_sel,
  input  logic [W-1:0] mt_data
`endif
);

  logic [1:0]   state;
  logic [1:0]   state_n;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         idle;
  logic         accept;
  logic         serve;
  logic         wd_tc;
  logic         abort;

  assign idle   = (state == S_IDLE);
  assign accept = idle & mult_req;
  // rd_valid gate: requester still holds mf_req in the cycle it sees rd_valid
  assign serve  = idle & mf_req & ~rd_valid;
  assign abort  = (state == S_WAIT) & ~mul_done & wd_tc;

  assign mult_ack = accept & ~rst;
  assign stall    = ~idle & mf_req & ~rd_valid;
  assign busy     = ~idle;
  assign mul_st   = (state == S_START);

  mul_watchdog #(
    .MAX_CYC(MAX_CYC)
  ) u_wd (
    .clk(clk),
    .rst(rst),
    .en (state == S_WAIT),
    .tc (wd_tc)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (mult_req) state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (mul_done)   state_n = S_CAPT;
        else if (wd_tc) state_n = S_IDLE;
      end
      S_CAPT:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mul_mndo <= '0;
      mul_mdor <= '0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_n;
      rd_valid <= serve;
      if (serve)
        rd_data <= (mf_sel == SEL_HI) ? hi : lo;
      if (accept) begin
        mul_mndo <= op_a;
        mul_mdor <= op_b;
        err      <= 1'b0;
      end else if (abort) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_CAPT) begin
      {hi, lo} <= mul_prod;
`ifdef MUL_HILO_MT_EN
    end else if (idle & mt_req) begin
      if (mt_sel == SEL_HI) hi <= mt_data;
      else                  lo <= mt_data;
`endif
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Self-checking bench for mul_hilo_ctrl with a behavioural multiplier.
// Directed cases plus random operands against a HI/LO reference value.
module tb_mul_hilo_ctrl;

  localparam int W       = 16;
  localparam int MAX_CYC = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          mult_req;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          mult_ack;
  logic          mf_req;
  logic          mf_sel;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          stall;
  logic          busy;
  logic          err;
  logic          mul_st;
  logic [W-1:0]  mul_mndo;
  logic [W-1:0]  mul_mdor;
  logic [2*W-1:0] mul_prod;
  logic          mul_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] hilo_m;
  int          mdelay;
  bit          done_tie0;

  int          mcnt;
  bit          mrun;
  logic [31:0] mprod;

  always #5 clk = ~clk;

  mul_hilo_ctrl #(
    .W(W),
    .MAX_CYC(MAX_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mult_req(mult_req),
    .op_a    (op_a),
    .op_b    (op_b),
    .mult_ack(mult_ack),
    .mf_req  (mf_req),
    .mf_sel  (mf_sel),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .stall   (stall),
    .busy    (busy),
    .err     (err),
    .mul_st  (mul_st),
    .mul_mndo(mul_mndo),
    .mul_mdor(mul_mdor),
    .mul_prod(mul_prod),
    .mul_done(mul_done)
`ifdef MUL_HILO_MT_EN
    ,
    .mt_req  (1'b0),
    .mt_sel  (1'b0),
    .mt_data ({W{1'b0}})
`endif
  );

  // Multiplier stand-in: product after mdelay+1 cycles, done held to next St
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mrun     <= 1'b0;
      mcnt     <= 0;
      mul_done <= 1'b0;
      mprod    <= '0;
    end else if (mul_st) begin
      mrun     <= 1'b1;
      mcnt     <= mdelay;
      mul_done <= 1'b0;
      mprod    <= 32'(mul_mndo) * 32'(mul_mdor);
    end else if (mrun) begin
      if (mcnt == 0) begin
        mrun     <= 1'b0;
        mul_done <= !done_tie0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  assign mul_prod = mprod;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin
      cyc();
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_read(input logic sel);
    int k;
    mf_req = 1'b1;
    mf_sel = sel;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!rd_valid && k < 50);
    chk("rd_valid", rd_valid, 1);
    chk(sel ? "rd_hi" : "rd_lo", rd_data,
        sel ? 32'(hilo_m[31:16]) : 32'(hilo_m[15:0]));
    mf_req = 1'b0;
  endtask

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a     = a;
    op_b     = b;
    mult_req = 1'b1;
    #1;
    chk("ack", mult_ack, 1);
    cyc();
    chk("st", mul_st, 1);
    chk("mndo", mul_mndo, 32'(a));
    chk("mdor", mul_mdor, 32'(b));
    chk("ack_busy", mult_ack, 0);
    chk("err_clr", err, 0);
    cyc();
    mult_req = 1'b0;
    chk("st_pulse", mul_st, 0);
    wait_idle(200);
    hilo_m = 32'(a) * 32'(b);
  endtask

  initial begin
    int k;
    int bc;
    int stall_bad;
    int idle_seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst       = 1'b1;
    mult_req  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    mf_req    = 1'b0;
    mf_sel    = 1'b0;
    mdelay    = 3;
    done_tie0 = 1'b0;
    hilo_m    = '0;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdd", rd_data, 0);
    chk("rst_st", mul_st, 0);
    chk("rst_mndo", mul_mndo, 0);
    rst = 1'b0;
    cyc();

    do_mult(16'd3, 16'd5);
    do_read(1'b0);
    do_read(1'b1);

    mdelay = 10;
    do_mult(16'hFFFF, 16'hFFFF);
    chk("ffff_model", hilo_m, 32'hFFFE_0001);
    do_read(1'b1);
    do_read(1'b0);

    // read issued one cycle after the ack waits behind the multiply
    mdelay   = 6;
    op_a     = 16'd7;
    op_b     = 16'd9;
    mult_req = 1'b1;
    #1;
    chk("ack_79", mult_ack, 1);
    cyc();
    mult_req = 1'b0;
    mf_req   = 1'b1;
    mf_sel   = 1'b0;
    #1;
    chk("stall_hi", stall, 1);
    chk("stall_nordv", rd_valid, 0);
    k = 0;
    stall_bad = 0;
    idle_seen = 0;
    while (!rd_valid && k < 200) begin
      if (busy && !stall) stall_bad++;
      if (!busy) idle_seen++;
      cyc();
      k++;
    end
    mf_req = 1'b0;
    hilo_m = 32'h0000_003F;
    chk("stall_rdv", rd_valid, 1);
    chk("stall_gap", stall_bad, 0);
    chk("stall_idle1", idle_seen, 1);
    chk("stall_data", rd_data, 32'h003F);
    cyc();
    chk("rdv_pulse", rd_valid, 0);

    // watchdog abort with done never arriving
    done_tie0 = 1'b1;
    op_a      = 16'h1234;
    op_b      = 16'h5678;
    mult_req  = 1'b1;
    cyc();
    mult_req = 1'b0;
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      cyc();
    end
    chk("wd_busy_cyc", bc, MAX_CYC + 1);
    chk("wd_err", err, 1);
    done_tie0 = 1'b0;
    do_read(1'b1);
    do_read(1'b0);
    cyc();
    chk("wd_err_sticky", err, 1);

    // reset in the middle of WAIT
    mdelay   = 40;
    op_a     = 16'h00FF;
    op_b     = 16'h0101;
    mult_req = 1'b1;
    #1;
    chk("ack_rst", mult_ack, 1);
    cyc();
    mult_req = 1'b0;
    chk("err_clr_acc", err, 0);
    for (int i = 0; i < 5; i++) cyc();
    chk("pre_rst_busy", busy, 1);
    mult_req = 1'b1;
    mf_req   = 1'b1;
    rst      = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_ack", mult_ack, 0);
    chk("mr_stall", stall, 0);
    chk("mr_st", mul_st, 0);
    chk("mr_rdd", rd_data, 0);
    chk("mr_mndo", mul_mndo, 0);
    chk("mr_mdor", mul_mdor, 0);
    cyc();
    mult_req = 1'b0;
    mf_req   = 1'b0;
    rst      = 1'b0;
    hilo_m   = '0;
    cyc();
    do_read(1'b0);
    do_read(1'b1);
    mdelay = 4;
    do_mult(16'h00FF, 16'h0101);
    do_read(1'b0);
    do_read(1'b1);

    // same-cycle multiply + read: old LO returned, new LO later
    do_mult(16'hAAAB, 16'd3);
    chk("pre_model", hilo_m, 32'h0002_0001);
    op_a     = 16'd4;
    op_b     = 16'd4;
    mult_req = 1'b1;
    mf_req   = 1'b1;
    mf_sel   = 1'b0;
    #1;
    chk("sc_ack", mult_ack, 1);
    cyc();
    mult_req = 1'b0;
    chk("sc_rdv", rd_valid, 1);
    chk("sc_rdd", rd_data, 32'h0001);
    chk("sc_busy", busy, 1);
    chk("sc_nostall", stall, 0);
    mf_req = 1'b0;
    wait_idle(200);
    hilo_m = 32'h0000_0010;
    do_read(1'b0);
    do_read(1'b1);

    for (int i = 0; i < 10; i++) begin
      ra     = W'($urandom);
      rb     = W'($urandom);
      mdelay = $urandom_range(0, 20);
      do_mult(ra, rb);
      do_read(1'($urandom_range(0, 1)));
      do_read(1'b1);
      do_read(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
